// File: rtl/reg_file_mp.sv
// Two-write, two-read register file with write-to-read bypass and a
// handshaked serial dump engine that streams a snapshot of every register.
module reg_file_mp #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] waddr_a,
  input  logic [WIDTH-1:0]  wdata_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] waddr_b,
  input  logic [WIDTH-1:0]  wdata_b,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata1,
  output logic [WIDTH-1:0]  rdata2,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [WIDTH-1:0]  dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   dump_addr_q;
  logic [WIDTH-1:0]    dump_data_q;
  logic                dump_valid_q;
  logic                dump_busy_q;
  logic                dump_done_q;
  logic [ADDR_W-1:0]   idx_d;
  logic [WIDTH-1:0]    snap_d;
  logic                wr_a_ok;
  logic                wr_b_ok;
  logic [WIDTH-1:0]    regs_q [DEPTH];

  function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
    return (32'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_a_ok = we_a && !reset && addr_legal(waddr_a);
  assign wr_b_ok = we_b && !reset && addr_legal(waddr_b);

  // Unimplemented addresses and the hard-wired zero register read as constant 0.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (gi >= NUM_REGS || (gi == 0 && ZERO_REG != 0)) begin : g_const
        assign regs_q[gi] = '0;
      end else begin : g_store
        logic [WIDTH-1:0] val_q;
        always_ff @(posedge clk) begin
          if (reset) begin
            val_q <= '0;
          end else if (wr_b_ok && waddr_b == ADDR_W'(gi)) begin
            val_q <= wdata_b;
          end else if (wr_a_ok && waddr_a == ADDR_W'(gi)) begin
            val_q <= wdata_a;
          end
        end
        assign regs_q[gi] = val_q;
      end
    end
  endgenerate

  // Value the register will hold after this edge: port B beats port A.
  function automatic logic [WIDTH-1:0] fwd(input logic [ADDR_W-1:0] a);
    if (wr_b_ok && waddr_b == a) return wdata_b;
    if (wr_a_ok && waddr_a == a) return wdata_a;
    return regs_q[a];
  endfunction

  always_comb begin
    idx_d  = (state_q == S_IDLE) ? '0 : dump_addr_q + ADDR_W'(1);
    rdata1 = fwd(raddr1);
    rdata2 = fwd(raddr2);
    snap_d = fwd(idx_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      dump_valid_q <= 1'b0;
      dump_busy_q  <= 1'b0;
      dump_done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dump_start) begin
            state_q      <= S_SEND;
            dump_addr_q  <= idx_d;
            dump_data_q  <= snap_d;
            dump_valid_q <= 1'b1;
            dump_busy_q  <= 1'b1;
          end
        end
        S_SEND: begin
          if (dump_ready) begin
            if (dump_addr_q == LAST_IDX) begin
              state_q      <= S_DONE;
              dump_valid_q <= 1'b0;
              dump_done_q  <= 1'b1;
            end else begin
              dump_addr_q <= idx_d;
              dump_data_q <= snap_d;
            end
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          dump_done_q <= 1'b0;
          dump_busy_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dump_valid = dump_valid_q;
  assign dump_addr  = dump_addr_q;
  assign dump_data  = dump_data_q;
  assign dump_busy  = dump_busy_q;
  assign dump_done  = dump_done_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed vector table, hand-written dump sequences and
// random traffic checked against an array-based reference model.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        we_a, we_b;
  logic [4:0]  waddr_a, waddr_b, raddr1, raddr2;
  logic [31:0] wdata_a, wdata_b;
  logic        dump_start, dump_ready;
  logic [31:0] rdata1, rdata2, dump_data;
  logic [4:0]  dump_addr;
  logic        dump_valid, dump_busy, dump_done;
  logic [31:0] s_rdata1, s_rdata2, s_dump_data;
  logic [4:0]  s_dump_addr;
  logic        s_dump_valid, s_dump_busy, s_dump_done;

  always #5 clk = ~clk;

  reg_file_mp #(.WIDTH(32), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_busy(dump_busy), .dump_done(dump_done));

  // Sixteen-register instance sharing all inputs, used for discard checks.
  reg_file_mp #(.WIDTH(32), .ADDR_W(5), .NUM_REGS(16), .ZERO_REG(1)) dut16 (
    .clk(clk), .reset(reset),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(s_rdata1), .rdata2(s_rdata2),
    .dump_start(dump_start), .dump_valid(s_dump_valid), .dump_ready(dump_ready),
    .dump_addr(s_dump_addr), .dump_data(s_dump_data),
    .dump_busy(s_dump_busy), .dump_done(s_dump_done));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: stored arrays, post-write arrays, dump progress.
  logic [31:0] m32 [32];
  logic [31:0] p32 [32];
  logic [31:0] m16 [16];
  logic [31:0] p16 [16];
  int          ds;       // 0 idle, 1 sending, 2 done
  int          didx;
  logic [31:0] ddata;

  typedef struct packed {
    logic        wa;
    logic [4:0]  aa;
    logic [31:0] da;
    logic        wb;
    logic [4:0]  ab;
    logic [31:0] db;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] e16;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd32(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : p32[a];
  endfunction

  function automatic logic [31:0] rd16(input logic [4:0] a);
    return (a == 5'd0 || a >= 5'd16) ? 32'd0 : p16[a[3:0]];
  endfunction

  // Apply this cycle's writes in time order (A then B), so B wins a tie.
  task automatic compute_post();
    p32 = m32;
    p16 = m16;
    if (!reset) begin
      if (we_a && waddr_a != 0) p32[waddr_a] = wdata_a;
      if (we_b && waddr_b != 0) p32[waddr_b] = wdata_b;
      if (we_a && waddr_a != 0 && waddr_a < 16) p16[waddr_a[3:0]] = wdata_a;
      if (we_b && waddr_b != 0 && waddr_b < 16) p16[waddr_b[3:0]] = wdata_b;
    end
  endtask

  task automatic check_outputs();
    chk("rdata1", rdata1, rd32(raddr1));
    chk("rdata2", rdata2, rd32(raddr2));
    chk("rdata1_n16", s_rdata1, rd16(raddr1));
    chk("rdata2_n16", s_rdata2, rd16(raddr2));
    chk("dump_valid", 32'(dump_valid), 32'(ds == 1));
    chk("dump_busy", 32'(dump_busy), 32'(ds != 0));
    chk("dump_done", 32'(dump_done), 32'(ds == 2));
    if (ds == 1) begin
      chk("dump_addr", 32'(dump_addr), 32'(didx));
      chk("dump_data", dump_data, ddata);
    end
  endtask

  task automatic commit();
    if (reset) begin
      foreach (m32[i]) m32[i] = '0;
      foreach (m16[i]) m16[i] = '0;
      ds = 0;
      didx = 0;
    end else begin
      case (ds)
        0: if (dump_start) begin ds = 1; didx = 0; ddata = rd32(5'd0); end
        1: if (dump_ready) begin
             if (didx == 31) ds = 2;
             else begin didx++; ddata = rd32(5'(didx)); end
           end
        default: ds = 0;
      endcase
      m32 = p32;
      m16 = p16;
    end
  endtask

  task automatic half_a();
    @(negedge clk);
    compute_post();
    check_outputs();
  endtask

  task automatic half_b();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic cycle();
    half_a();
    half_b();
  endtask

  task automatic idle_inputs();
    we_a = 0; we_b = 0; waddr_a = 0; waddr_b = 0; wdata_a = 0; wdata_b = 0;
    raddr1 = 0; raddr2 = 0; dump_start = 0; dump_ready = 0;
  endtask

  initial begin
    int beats, dones, stalled, guard;
    foreach (m32[i]) m32[i] = '0;
    foreach (m16[i]) m16[i] = '0;
    ds = 0; didx = 0; ddata = 0;
    reset = 1;
    idle_inputs();

    vecs[0]  = '{1'b1, 5'd3,  32'h11,       1'b0, 5'd0, 32'h0,  5'd3,  5'd0, 32'h11,   32'h0,  32'h11};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  5'd3,  5'd0, 32'h11,   32'h0,  32'h11};
    vecs[2]  = '{1'b1, 5'd5,  32'hAA,       1'b1, 5'd5, 32'hBB, 5'd5,  5'd3, 32'hBB,   32'h11, 32'hBB};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  5'd5,  5'd4, 32'hBB,   32'h0,  32'hBB};
    vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,  5'd0,  5'd5, 32'h0,    32'hBB, 32'h0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  5'd0,  5'd0, 32'h0,    32'h0,  32'h0};
    vecs[6]  = '{1'b1, 5'd20, 32'h1234,     1'b0, 5'd0, 32'h0,  5'd20, 5'd5, 32'h1234, 32'hBB, 32'h0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  5'd20, 5'd3, 32'h1234, 32'h11, 32'h0};
    vecs[8]  = '{1'b1, 5'd7,  32'h77,       1'b1, 5'd9, 32'h99, 5'd7,  5'd9, 32'h77,   32'h99, 32'h77};
    vecs[9]  = '{1'b1, 5'd31, 32'hCAFE,     1'b1, 5'd7, 32'h7B, 5'd31, 5'd7, 32'hCAFE, 32'h7B, 32'h0};
    vecs[10] = '{1'b1, 5'd9,  32'h5,        1'b1, 5'd9, 32'h6,  5'd9,  5'd7, 32'h6,    32'h7B, 32'h6};

    cycle();
    cycle();
    reset = 0;
    chk("rst_dump_valid", 32'(dump_valid), 32'd0);
    chk("rst_dump_busy", 32'(dump_busy), 32'd0);
    chk("rst_dump_done", 32'(dump_done), 32'd0);
    chk("rst_dump_addr", 32'(dump_addr), 32'd0);
    chk("rst_dump_data", dump_data, 32'd0);

    // Directed vector table
    foreach (vecs[i]) begin
      we_a = vecs[i].wa; waddr_a = vecs[i].aa; wdata_a = vecs[i].da;
      we_b = vecs[i].wb; waddr_b = vecs[i].ab; wdata_b = vecs[i].db;
      raddr1 = vecs[i].r1; raddr2 = vecs[i].r2;
      half_a();
      chk($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].e1);
      chk($sformatf("vec%0d_rdata2", i), rdata2, vecs[i].e2);
      chk($sformatf("vec%0d_rdata1_n16", i), s_rdata1, vecs[i].e16);
      half_b();
    end
    idle_inputs();

    // Load reg i = 4*i, two registers per cycle
    for (int i = 0; i < 16; i++) begin
      we_a = 1; waddr_a = 5'(2 * i);     wdata_a = 32'(8 * i);
      we_b = 1; waddr_b = 5'(2 * i + 1); wdata_b = 32'(8 * i + 4);
      cycle();
    end
    idle_inputs();

    // Full dump with dump_ready held high
    dump_start = 1; dump_ready = 1;
    cycle();
    dump_start = 0;
    beats = 0; dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (dump_valid) begin
        chk("full_beat_addr", 32'(dump_addr), 32'(beats));
        chk("full_beat_data", dump_data, 32'(beats * 4));
        beats++;
      end
      if (dump_done) dones++;
      cycle();
    end
    chk("full_beat_count", 32'(beats), 32'd32);
    chk("full_done_count", 32'(dones), 32'd1);

    // Stall at beat 7 while port A overwrites reg 7
    dump_start = 1; dump_ready = 1;
    cycle();
    dump_start = 0;
    stalled = 0; dones = 0;
    for (int c = 0; c < 60; c++) begin
      if (dump_valid && dump_addr == 5'd7 && stalled < 5) begin
        chk("stall_data", dump_data, 32'd28);
        dump_ready = 0; we_a = 1; waddr_a = 5'd7; wdata_a = 32'hDEAD;
        stalled++;
      end else begin
        dump_ready = 1; we_a = 0;
        if (dump_valid && dump_addr == 5'd7) chk("stall_accept_data", dump_data, 32'd28);
        if (dump_valid && dump_addr == 5'd8) chk("after_stall_data", dump_data, 32'd32);
      end
      if (dump_done) dones++;
      cycle();
    end
    chk("stall_cycles", 32'(stalled), 32'd5);
    chk("stall_done_count", 32'(dones), 32'd1);
    raddr1 = 5'd7;
    #1;
    chk("reg7_after_stall", rdata1, 32'hDEAD);
    idle_inputs();

    // Reset in the middle of a dump
    dump_start = 1; dump_ready = 1;
    cycle();
    dump_start = 0;
    guard = 0;
    while (!(dump_valid && dump_addr == 5'd10) && guard < 40) begin
      cycle();
      guard++;
    end
    chk("reach_beat10", 32'(guard < 40), 32'd1);
    reset = 1;
    cycle();
    reset = 0;
    raddr1 = 5'd7; raddr2 = 5'd31;
    #1;
    chk("abort_valid", 32'(dump_valid), 32'd0);
    chk("abort_busy", 32'(dump_busy), 32'd0);
    chk("abort_read7", rdata1, 32'd0);
    chk("abort_read31", rdata2, 32'd0);
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      if (dump_done) dones++;
      cycle();
    end
    chk("abort_no_done", 32'(dones), 32'd0);

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      we_a = 1'($urandom); waddr_a = 5'($urandom); wdata_a = $urandom;
      we_b = 1'($urandom); waddr_b = 5'($urandom); wdata_b = $urandom;
      if ($urandom_range(0, 3) == 0) waddr_b = waddr_a;
      raddr1 = ($urandom_range(0, 2) == 0) ? waddr_b : 5'($urandom);
      raddr2 = ($urandom_range(0, 2) == 0) ? waddr_a : 5'($urandom);
      dump_start = ($urandom_range(0, 7) == 0);
      dump_ready = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 149) == 0);
      cycle();
    end
    reset = 0;
    idle_inputs();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
